// File: rtl/adc_uart_pkg.sv
// Shared types and helpers for the ADC scan-and-transmit controller.
//   seq_state_t : channel sequencer states (select, convert, transmit, advance)
//   tx_state_t  : UART frame serialiser states
//   parity_bit  : parity of a payload (even or odd sense)
package adc_uart_pkg;

    typedef enum logic [2:0] {
        S_SEL,
        S_SOC,
        S_WAIT,
        S_TAG,
        S_DATA,
        S_NEXT
    } seq_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } tx_state_t;

    // Widest payload the serialiser supports; narrower payloads are zero-extended.
    localparam int MAX_DATA_W = 16;

    // Zero padding does not change the XOR, so any DATA_W up to 16 fits.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start bit, payload MSB first, optional parity, stop bits.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : request a frame (honoured only while idle)
//   payload      : frame payload, captured on an accepted start
//   dsr_ok       : receiver ready; a start with dsr_ok=0 is refused
//   busy         : 1 from the first start-bit clock to the last stop-bit clock
//   done         : 1-cycle pulse in the last clock of the final stop bit
//   line         : serial output, idle high
module uart_tx_frame
    import adc_uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BAUD_DIV   = 104,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] payload,
    input  logic              dsr_ok,
    output logic              busy,
    output logic              done,
    output logic              line
);

    localparam int BAUD_W = $clog2(BAUD_DIV);
    // DATA_W >= 4, so this counter also covers the stop-bit index.
    localparam int BIT_W  = $clog2(DATA_W);

    tx_state_t          state_q, state_d;
    logic [BAUD_W-1:0]  baud_q,  baud_d;
    logic [BIT_W-1:0]   bit_q,   bit_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               par_q,   par_d;
    logic               baud_last;

    assign baud_last = (baud_q == BAUD_W'(BAUD_DIV - 1));
    assign busy      = (state_q != TX_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done    = 1'b0;

        // Baud counter runs only inside a frame and restarts at every bit boundary.
        if (state_q != TX_IDLE) begin
            baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            TX_IDLE: begin
                if (start && dsr_ok) begin
                    state_d = TX_START;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = payload;
                    par_d   = parity_bit(MAX_DATA_W'(payload), PARITY_ODD != 0);
                end
            end
            TX_START: begin
                if (baud_last) state_d = TX_DATA;
            end
            TX_DATA: begin
                if (baud_last) begin
                    shift_d = shift_q << 1;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? TX_PAR : TX_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            TX_PAR: begin
                if (baud_last) state_d = TX_STOP;
            end
            TX_STOP: begin
                if (baud_last) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        done    = 1'b1;
                        state_d = TX_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        line = 1'b1;
        case (state_q)
            TX_START: line = 1'b0;
            TX_DATA:  line = shift_q[DATA_W-1];
            TX_PAR:   line = par_q;
            default:  line = 1'b1;
        endcase
    end

endmodule

// File: rtl/adc_uart_scan_tx.sv
// ADC scan-and-transmit controller. Steps through NUM_CH mux channels, converts each,
// captures the sample and sends it as a UART frame, optionally preceded by a channel tag.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   eoc, data_in : ADC end-of-conversion and sample
//   dsr          : receiver ready, checked when each frame starts
//   mux_en       : analog mux enable;  canale : selected channel
//   soc          : start of conversion; load_dato : sample-register load pulse
//   add_mpx2     : data frame (not tag frame) in progress
//   data_out     : serial line;  tx_busy : frame on the line
//   error        : sticky; set by timeout or refused frame, cleared by a completed data frame
module adc_uart_scan_tx
    import adc_uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 8,
    parameter int CH_W       = $clog2(NUM_CH),
    parameter int BAUD_DIV   = 104,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int TAG_EN     = 1,
    parameter int EOC_TMO    = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              eoc,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dsr,
    output logic              mux_en,
    output logic [CH_W-1:0]   canale,
    output logic              soc,
    output logic              load_dato,
    output logic              add_mpx2,
    output logic              data_out,
    output logic              tx_busy,
    output logic              error
);

    localparam int TMO_W = $clog2(EOC_TMO + 1);

    seq_state_t         state_q,  state_d;
    logic [CH_W-1:0]    canale_q, canale_d;
    logic [DATA_W-1:0]  sample_q, sample_d;
    logic               error_q,  error_d;
    logic [TMO_W-1:0]   tmo_q,    tmo_d;
    logic               sent_q,   sent_d;   // current frame has been accepted by the serialiser

    logic               mux_en_c;
    logic               tx_start;
    logic [DATA_W-1:0]  tx_payload;
    logic               tx_done;
    logic               err_set;
    logic               err_clr;

    uart_tx_frame #(
        .DATA_W     (DATA_W),
        .BAUD_DIV   (BAUD_DIV),
        .STOP_BITS  (STOP_BITS),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD)
    ) u_tx (
        .clock   (clock),
        .reset   (reset),
        .start   (tx_start),
        .payload (tx_payload),
        .dsr_ok  (dsr),
        .busy    (tx_busy),
        .done    (tx_done),
        .line    (data_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_SEL;
            canale_q <= '0;
            sample_q <= '0;
            error_q  <= 1'b0;
            tmo_q    <= '0;
            sent_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            canale_q <= canale_d;
            sample_q <= sample_d;
            error_q  <= error_d;
            tmo_q    <= tmo_d;
            sent_q   <= sent_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        canale_d   = canale_q;
        sample_d   = sample_q;
        tmo_d      = '0;           // timeout count only survives while waiting for eoc
        sent_d     = sent_q;
        mux_en_c   = 1'b0;
        soc        = 1'b0;
        load_dato  = 1'b0;
        add_mpx2   = 1'b0;
        tx_start   = 1'b0;
        tx_payload = sample_q;
        err_set    = 1'b0;
        err_clr    = 1'b0;

        case (state_q)
            S_SEL: begin
                mux_en_c = 1'b1;
                state_d  = S_SOC;
            end
            S_SOC: begin
                mux_en_c = 1'b1;
                soc      = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // A sample arriving on the last timeout clock still counts.
                if (eoc) begin
                    load_dato = 1'b1;
                    sample_d  = data_in;
                    state_d   = (TAG_EN != 0) ? S_TAG : S_DATA;
                end else if (tmo_q == TMO_W'(EOC_TMO - 1)) begin
                    err_set = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    mux_en_c = 1'b1;
                    soc      = 1'b1;
                    tmo_d    = tmo_q + TMO_W'(1);
                end
            end
            S_TAG, S_DATA: begin
                add_mpx2 = (state_q == S_DATA);
                if (state_q == S_TAG) tx_payload = DATA_W'(canale_q);
                // One start request on entry; a refused start drops the whole sample.
                if (!sent_q) begin
                    tx_start = 1'b1;
                    if (dsr) begin
                        sent_d = 1'b1;
                    end else begin
                        err_set = 1'b1;
                        state_d = S_NEXT;
                    end
                end else if (tx_done) begin
                    sent_d  = 1'b0;
                    err_clr = (state_q == S_DATA);
                    state_d = (state_q == S_TAG) ? S_DATA : S_NEXT;
                end
            end
            S_NEXT: begin
                canale_d = (canale_q == CH_W'(NUM_CH - 1)) ? '0 : canale_q + CH_W'(1);
                state_d  = S_SEL;
            end
            default: state_d = S_SEL;
        endcase

        // Set has priority over clear when both happen in one cycle.
        if (err_set)      error_d = 1'b1;
        else if (err_clr) error_d = 1'b0;
        else              error_d = error_q;
    end

    // The sequencer idles in S_SEL during reset; keep the mux disabled until reset is released.
    assign mux_en = mux_en_c & ~reset;
    assign canale = canale_q;
    assign error  = error_q;

endmodule

// File: tb/tb_adc_uart_scan_tx.sv
`timescale 1ns/1ps
module tb_adc_uart_scan_tx;

    localparam int A_BAUD = 104;
    localparam int A_TMO  = 1023;
    localparam int B_BAUD = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Instance A: default parameters
    logic       eoc_a = 1'b0, dsr_a = 1'b1;
    logic [7:0] data_a = 8'h00;
    logic       mux_en_a, soc_a, load_a, add_a, line_a, busy_a, err_a;
    logic [2:0] canale_a;

    // Instance B: 3 channels, no tag, odd parity, 2 stop bits, fast baud
    logic       eoc_b = 1'b0, dsr_b = 1'b1;
    logic [7:0] data_b = 8'h00;
    logic       mux_en_b, soc_b, load_b, add_b, line_b, busy_b, err_b;
    logic [1:0] canale_b;

    adc_uart_scan_tx dut_a (
        .clock(clock), .reset(reset), .eoc(eoc_a), .data_in(data_a), .dsr(dsr_a),
        .mux_en(mux_en_a), .canale(canale_a), .soc(soc_a), .load_dato(load_a),
        .add_mpx2(add_a), .data_out(line_a), .tx_busy(busy_a), .error(err_a)
    );

    adc_uart_scan_tx #(
        .NUM_CH(3), .BAUD_DIV(B_BAUD), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1),
        .TAG_EN(0), .EOC_TMO(20)
    ) dut_b (
        .clock(clock), .reset(reset), .eoc(eoc_b), .data_in(data_b), .dsr(dsr_b),
        .mux_en(mux_en_b), .canale(canale_b), .soc(soc_b), .load_dato(load_b),
        .add_mpx2(add_b), .data_out(line_b), .tx_busy(busy_b), .error(err_b)
    );

    int passed = 0;
    int total  = 0;
    int ld_cnt_b = 0;

    typedef struct {
        logic [31:0] bits;   // bit 0 = start bit
        int          len;    // frame length in clocks
    } frame_t;

    frame_t exp_a[$];
    frame_t exp_b[$];

    // Count load_dato pulses of B well after the negedge input updates settle.
    always begin
        @(negedge clock);
        #2;
        if (load_b === 1'b1) ld_cnt_b++;
    end

    function automatic frame_t make_frame(input logic [7:0] payload, input int baud,
                                          input bit par_en, input bit odd, input int stops);
        frame_t f;
        int n;
        int ones;
        f.bits = '0;
        n = 1;        // start bit is 0
        ones = 0;
        for (int i = 7; i >= 0; i--) begin
            f.bits[n] = payload[i];
            if (payload[i]) ones++;
            n++;
        end
        if (par_en) begin
            f.bits[n] = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
            n++;
        end
        for (int i = 0; i < stops; i++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.len = n * baud;
        return f;
    endfunction

    function automatic logic cur_busy(input bit which);
        return which ? busy_b : busy_a;
    endfunction

    function automatic logic cur_line(input bit which);
        return which ? line_b : line_a;
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    // Waits (bounded) for a frame, samples each bit mid-period, measures its length.
    task automatic capture(input bit which, input int baud, output logic [31:0] bits,
                           output int len, output bit got);
        int n;
        bits = '0;
        len  = 0;
        got  = 1'b0;
        n    = 0;
        while (cur_busy(which) !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if (cur_busy(which) !== 1'b1) return;
        got = 1'b1;
        while (cur_busy(which) === 1'b1 && len < 40 * baud) begin
            if ((len % baud) == (baud / 2) && (len / baud) < 32) bits[len / baud] = cur_line(which);
            len++;
            tick();
        end
    endtask

    logic [31:0] bits;
    int          len;
    bit          got;
    frame_t      exp;

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (line_a !== 1'b1)    $display("FAIL reset_data_out: got %b want 1", line_a);    else passed++;
        total++; if (busy_a !== 1'b0)    $display("FAIL reset_tx_busy: got %b want 0", busy_a);     else passed++;
        total++; if (mux_en_a !== 1'b0)  $display("FAIL reset_mux_en: got %b want 0", mux_en_a);    else passed++;
        total++; if (soc_a !== 1'b0)     $display("FAIL reset_soc: got %b want 0", soc_a);          else passed++;
        total++; if (load_a !== 1'b0)    $display("FAIL reset_load_dato: got %b want 0", load_a);   else passed++;
        total++; if (add_a !== 1'b0)     $display("FAIL reset_add_mpx2: got %b want 0", add_a);     else passed++;
        total++; if (canale_a !== 3'd0)  $display("FAIL reset_canale: got %0d want 0", canale_a);   else passed++;
        total++; if (err_a !== 1'b0)     $display("FAIL reset_error: got %b want 0", err_a);        else passed++;
        reset = 1'b0;
        #1;
        total++; if (mux_en_a !== 1'b1)  $display("FAIL sel_mux_en: got %b want 1", mux_en_a);      else passed++;
    endtask

    task automatic test_first_sample();
        int n;
        n = 0;
        while (soc_a !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (soc_a !== 1'b1) $display("FAIL soc_rise: got %b want 1", soc_a); else passed++;
        repeat (5) tick();
        eoc_a  = 1'b1;
        data_a = 8'hA5;
        exp_a.push_back(make_frame(8'h00, A_BAUD, 0, 0, 1));
        exp_a.push_back(make_frame(8'hA5, A_BAUD, 0, 0, 1));
        #1;
        total++; if (load_a !== 1'b1)   $display("FAIL load_dato_pulse: got %b want 1", load_a);   else passed++;
        total++; if (soc_a !== 1'b0)    $display("FAIL soc_drop_on_eoc: got %b want 0", soc_a);    else passed++;
        total++; if (mux_en_a !== 1'b0) $display("FAIL mux_drop_on_eoc: got %b want 0", mux_en_a); else passed++;
        tick();
        eoc_a = 1'b0;
        #1;
        total++; if (load_a !== 1'b0)   $display("FAIL load_dato_width: got %b want 0", load_a);   else passed++;
        total++; if (add_a !== 1'b0)    $display("FAIL add_mpx2_tag: got %b want 0", add_a);       else passed++;
        capture(0, A_BAUD, bits, len, got);
        exp = exp_a.pop_front();
        total++; if (!got || bits !== exp.bits) $display("FAIL tag0_bits: got %b want %b", bits, exp.bits); else passed++;
        total++; if (len !== exp.len) $display("FAIL tag0_len: got %0d want %0d", len, exp.len); else passed++;
        total++; if (add_a !== 1'b1)    $display("FAIL add_mpx2_data: got %b want 1", add_a);      else passed++;
        capture(0, A_BAUD, bits, len, got);
        exp = exp_a.pop_front();
        total++; if (!got || bits !== exp.bits) $display("FAIL data_a5_bits: got %b want %b", bits, exp.bits); else passed++;
        total++; if (len !== exp.len) $display("FAIL data_a5_len: got %0d want %0d", len, exp.len); else passed++;
        total++; if (line_a !== 1'b1)   $display("FAIL idle_line: got %b want 1", line_a);         else passed++;
        tick();
        total++; if (canale_a !== 3'd1) $display("FAIL canale_adv1: got %0d want 1", canale_a);    else passed++;
    endtask

    task automatic test_timeout();
        int n;
        int hi;
        n = 0;
        while (soc_a !== 1'b1 && n < 20) begin tick(); n++; end
        hi = 0;
        while (soc_a === 1'b1 && hi < 1100) begin hi++; tick(); end
        total++; if (hi !== A_TMO) $display("FAIL tmo_soc_cycles: got %0d want %0d", hi, A_TMO); else passed++;
        tick();
        total++; if (err_a !== 1'b1)    $display("FAIL tmo_error: got %b want 1", err_a);          else passed++;
        total++; if (busy_a !== 1'b0)   $display("FAIL tmo_no_frame: got %b want 0", busy_a);      else passed++;
        tick();
        total++; if (canale_a !== 3'd2) $display("FAIL tmo_canale: got %0d want 2", canale_a);     else passed++;
        n = 0;
        while (soc_a !== 1'b1 && n < 20) begin tick(); n++; end
        repeat (3) tick();
        eoc_a  = 1'b1;
        data_a = 8'h3C;
        exp_a.push_back(make_frame(8'h02, A_BAUD, 0, 0, 1));
        exp_a.push_back(make_frame(8'h3C, A_BAUD, 0, 0, 1));
        tick();
        eoc_a = 1'b0;
        capture(0, A_BAUD, bits, len, got);
        exp = exp_a.pop_front();
        total++; if (!got || bits !== exp.bits) $display("FAIL tag2_bits: got %b want %b", bits, exp.bits); else passed++;
        total++; if (err_a !== 1'b1) $display("FAIL error_kept_by_tag: got %b want 1", err_a); else passed++;
        capture(0, A_BAUD, bits, len, got);
        exp = exp_a.pop_front();
        total++; if (!got || bits !== exp.bits) $display("FAIL data_3c_bits: got %b want %b", bits, exp.bits); else passed++;
        total++; if (err_a !== 1'b0) $display("FAIL error_clear: got %b want 0", err_a); else passed++;
    endtask

    task automatic test_dsr_refuse();
        int n;
        int bad;
        n = 0;
        while (soc_a !== 1'b1 && n < 20) begin tick(); n++; end
        repeat (2) tick();
        eoc_a  = 1'b1;
        data_a = 8'h5A;
        exp_a.push_back(make_frame(8'h03, A_BAUD, 0, 0, 1));
        tick();
        eoc_a = 1'b0;
        capture(0, A_BAUD, bits, len, got);
        exp = exp_a.pop_front();
        total++; if (!got || bits !== exp.bits) $display("FAIL tag3_bits: got %b want %b", bits, exp.bits); else passed++;
        dsr_a = 1'b0;                 // data frame start is refused
        tick();
        total++; if (err_a !== 1'b1)    $display("FAIL dsr_error: got %b want 1", err_a);          else passed++;
        tick();
        total++; if (canale_a !== 3'd4) $display("FAIL dsr_canale: got %0d want 4", canale_a);     else passed++;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (line_a !== 1'b1 || busy_a !== 1'b0) bad++;
            tick();
        end
        total++; if (bad !== 0) $display("FAIL dsr_line_idle: got %0d active cycles want 0", bad); else passed++;
        dsr_a = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int n;
        eoc_a  = 1'b1;
        data_a = 8'h00;
        exp_a.push_back(make_frame(8'h04, A_BAUD, 0, 0, 1));
        tick();
        eoc_a = 1'b0;
        capture(0, A_BAUD, bits, len, got);
        exp = exp_a.pop_front();
        total++; if (!got || bits !== exp.bits) $display("FAIL tag4_bits: got %b want %b", bits, exp.bits); else passed++;
        n = 0;
        while (busy_a !== 1'b1 && n < 10) begin tick(); n++; end
        repeat (5 * A_BAUD + A_BAUD / 2) tick();    // middle of payload bit 4
        total++; if (line_a !== 1'b0)   $display("FAIL mid_bit4_line: got %b want 0", line_a);     else passed++;
        reset = 1'b1;
        tick();
        total++; if (line_a !== 1'b1)   $display("FAIL rst_mid_line: got %b want 1", line_a);      else passed++;
        total++; if (busy_a !== 1'b0)   $display("FAIL rst_mid_busy: got %b want 0", busy_a);      else passed++;
        total++; if (canale_a !== 3'd0) $display("FAIL rst_mid_canale: got %0d want 0", canale_a); else passed++;
        total++; if (mux_en_a !== 1'b0) $display("FAIL rst_mid_mux_en: got %b want 0", mux_en_a);  else passed++;
        reset = 1'b0;
        #1;
        total++; if (mux_en_a !== 1'b1) $display("FAIL restart_mux_en: got %b want 1", mux_en_a);  else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] pat [5];
        int n;
        int base;
        pat = '{8'h01, 8'h7E, 8'h07, 8'hFF, 8'h96};
        base = ld_cnt_b;
        for (int s = 0; s < 5; s++) begin
            n = 0;
            while (soc_b !== 1'b1 && n < 100) begin tick(); n++; end
            total++; if (canale_b !== 2'(s % 3)) $display("FAIL wrap_canale_%0d: got %0d want %0d", s, canale_b, s % 3); else passed++;
            tick();
            eoc_b  = 1'b1;
            data_b = pat[s];
            exp_b.push_back(make_frame(pat[s], B_BAUD, 1, 1, 2));
            tick();
            eoc_b = 1'b0;
            capture(1, B_BAUD, bits, len, got);
            exp = exp_b.pop_front();
            total++; if (!got || bits !== exp.bits) $display("FAIL wrap_bits_%0d: got %b want %b", s, bits, exp.bits); else passed++;
            total++; if (len !== exp.len) $display("FAIL wrap_len_%0d: got %0d want %0d", s, len, exp.len); else passed++;
        end
        total++; if (ld_cnt_b - base !== 5) $display("FAIL load_dato_count: got %0d want 5", ld_cnt_b - base); else passed++;
    endtask

    task automatic test_parity();
        int n;
        n = 0;
        while (soc_b !== 1'b1 && n < 100) begin tick(); n++; end
        tick();
        eoc_b  = 1'b1;
        data_b = 8'h03;
        tick();
        eoc_b = 1'b0;
        capture(1, B_BAUD, bits, len, got);
        // start 0, payload 00000011, odd parity 1, two stop 1s
        total++; if (!got || bits !== 32'h0000_0F80) $display("FAIL parity_frame_bits: got %b want %b", bits, 32'h0000_0F80); else passed++;
        total++; if (len !== 12 * B_BAUD) $display("FAIL parity_frame_len: got %0d want %0d", len, 12 * B_BAUD); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_timeout();
        test_dsr_refuse();
        test_reset_mid_frame();
        test_wrap();
        test_parity();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
